// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB plus 2-bit PHT predictor with branch/miss statistics.
// Define BPU_GSHARE_EN to index the PHT with fetch index XOR global history (gshare).
module branch_predictor #(
    parameter int         ENTRIES  = 64,
    parameter int         GHR_BITS = 6,
    parameter logic [1:0] CNT_INIT = 2'b01,
    localparam int        IDX_W    = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      fetch_pc_i,
    output logic             pred_taken_o,
    output logic [31:0]      pred_target_o,
    output logic [IDX_W-1:0] pred_idx_o,
    input  logic             upd_valid_i,
    input  logic [31:0]      upd_pc_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    input  logic [31:0]      upd_target_i,
    input  logic             upd_miss_i,
    output logic [31:0]      branch_cnt_o,
    output logic [31:0]      miss_cnt_o
);

    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] r_btbValid;
    logic [TAG_W-1:0]   r_btbTag    [ENTRIES];
    logic [31:0]        r_btbTarget [ENTRIES];
    logic [1:0]         r_pht       [ENTRIES];
    logic [31:0]        r_branchCnt;
    logic [31:0]        r_missCnt;

    logic [IDX_W-1:0]   w_fetchIdx;
    logic [IDX_W-1:0]   w_updPcIdx;
    logic [IDX_W-1:0]   w_predIdx;
    logic [TAG_W-1:0]   w_fetchTag;
    logic [TAG_W-1:0]   w_updTag;
    logic               w_hit;
    logic               w_predTaken;
    logic               w_unused;

    assign w_fetchIdx = fetch_pc_i[IDX_W+1:2];
    assign w_fetchTag = fetch_pc_i[31:IDX_W+2];
    assign w_updPcIdx = upd_pc_i[IDX_W+1:2];
    assign w_updTag   = upd_pc_i[31:IDX_W+2];
    assign w_unused   = ^{fetch_pc_i[1:0], upd_pc_i[1:0]};

`ifdef BPU_GSHARE_EN
    logic [GHR_BITS-1:0] r_ghr;

    // History is trained at resolution only; the cast keeps the low bits of the shifted vector.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ghr <= '0;
        end else if (upd_valid_i) begin
            r_ghr <= GHR_BITS'({r_ghr, upd_taken_i});
        end
    end

    assign w_predIdx = w_fetchIdx ^ IDX_W'(r_ghr);
`else
    assign w_predIdx = w_fetchIdx;
`endif

    // Lookup reads pre-update state; no bypass from the update port.
    assign w_hit         = r_btbValid[w_fetchIdx] && (r_btbTag[w_fetchIdx] == w_fetchTag);
    assign w_predTaken   = w_hit && r_pht[w_predIdx][1];
    assign pred_taken_o  = w_predTaken;
    assign pred_target_o = w_predTaken ? r_btbTarget[w_fetchIdx] : fetch_pc_i + 32'd4;
    assign pred_idx_o    = w_predIdx;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_pht[i] <= CNT_INIT;
            end
        end else if (upd_valid_i) begin
            if (upd_taken_i && (r_pht[upd_idx_i] != 2'b11)) begin
                r_pht[upd_idx_i] <= r_pht[upd_idx_i] + 2'd1;
            end else if (!upd_taken_i && (r_pht[upd_idx_i] != 2'b00)) begin
                r_pht[upd_idx_i] <= r_pht[upd_idx_i] - 2'd1;
            end
        end
    end

    // Only the valid bits need clearing; tag and target are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_btbValid <= '0;
        end else if (upd_valid_i && upd_taken_i) begin
            r_btbValid[w_updPcIdx]  <= 1'b1;
            r_btbTag[w_updPcIdx]    <= w_updTag;
            r_btbTarget[w_updPcIdx] <= upd_target_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_branchCnt <= '0;
            r_missCnt   <= '0;
        end else if (upd_valid_i) begin
            if (r_branchCnt != '1) begin
                r_branchCnt <= r_branchCnt + 32'd1;
            end
            if (upd_miss_i && (r_missCnt != '1)) begin
                r_missCnt <= r_missCnt + 32'd1;
            end
        end
    end

    assign branch_cnt_o = r_branchCnt;
    assign miss_cnt_o   = r_missCnt;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed test-plan scenarios plus randomized traffic checked
// against a behavioural table model of the predictor.
module tb_branch_predictor;

    localparam int ENTRIES  = 64;
    localparam int IDX_W    = $clog2(ENTRIES);
    localparam int GHR_BITS = 6;

    logic             clk;
    logic             reset_n;
    logic [31:0]      fetchPc;
    logic             predTaken;
    logic [31:0]      predTarget;
    logic [IDX_W-1:0] predIdx;
    logic             updValid;
    logic [31:0]      updPc;
    logic [IDX_W-1:0] updIdx;
    logic             updTaken;
    logic [31:0]      updTarget;
    logic             updMiss;
    logic [31:0]      branchCnt;
    logic [31:0]      missCnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain arrays and integer arithmetic.
    int          phtModel    [ENTRIES];
    bit          validModel  [ENTRIES];
    int unsigned tagModel    [ENTRIES];
    int unsigned targetModel [ENTRIES];
    longint      branchModel;
    longint      missModel;
    int unsigned ghrModel;

    branch_predictor #(
        .ENTRIES  (ENTRIES),
        .GHR_BITS (GHR_BITS),
        .CNT_INIT (2'b01)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fetch_pc_i    (fetchPc),
        .pred_taken_o  (predTaken),
        .pred_target_o (predTarget),
        .pred_idx_o    (predIdx),
        .upd_valid_i   (updValid),
        .upd_pc_i      (updPc),
        .upd_idx_i     (updIdx),
        .upd_taken_i   (updTaken),
        .upd_target_i  (updTarget),
        .upd_miss_i    (updMiss),
        .branch_cnt_o  (branchCnt),
        .miss_cnt_o    (missCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned pcIndex(input int unsigned pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned pcTag(input int unsigned pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            phtModel[i]   = 1;
            validModel[i] = 1'b0;
        end
        branchModel = 0;
        missModel   = 0;
        ghrModel    = 0;
    endtask

    task automatic modelUpdate(input int unsigned pc, input int unsigned idx, input bit taken,
                               input int unsigned target, input bit miss);
        if (taken) begin
            phtModel[idx] = (phtModel[idx] < 3) ? phtModel[idx] + 1 : 3;
            validModel[pcIndex(pc)]  = 1'b1;
            tagModel[pcIndex(pc)]    = pcTag(pc);
            targetModel[pcIndex(pc)] = target;
        end else begin
            phtModel[idx] = (phtModel[idx] > 0) ? phtModel[idx] - 1 : 0;
        end
        if (branchModel < 64'hFFFF_FFFF) branchModel++;
        if (miss && missModel < 64'hFFFF_FFFF) missModel++;
        ghrModel = ((ghrModel * 2) + (taken ? 1 : 0)) % (1 << GHR_BITS);
    endtask

    // One clock cycle: drive, compare the lookup against the model, clock, then advance the model.
    task automatic applyStimulus(input logic [31:0] fPc, input bit uValid, input logic [31:0] uPc,
                                 input int unsigned uIdx, input bit uTaken, input logic [31:0] uTarget,
                                 input bit uMiss);
        int unsigned idx;
        int unsigned pIdx;
        bit          expTaken;
        logic [31:0] expTarget;
        fetchPc   = fPc;
        updValid  = uValid;
        updPc     = uPc;
        updIdx    = IDX_W'(uIdx);
        updTaken  = uTaken;
        updTarget = uTarget;
        updMiss   = uMiss;
        #3;
        idx = pcIndex(fPc);
`ifdef BPU_GSHARE_EN
        pIdx = idx ^ ghrModel;
`else
        pIdx = idx;
`endif
        expTaken  = validModel[idx] && (tagModel[idx] == pcTag(fPc)) && (phtModel[pIdx] >= 2);
        expTarget = expTaken ? targetModel[idx] : fPc + 32'd4;
        checkOutput("pred_taken", {31'd0, predTaken}, {31'd0, expTaken});
        checkOutput("pred_target", predTarget, expTarget);
        checkOutput("pred_idx", {{(32-IDX_W){1'b0}}, predIdx}, pIdx);
        checkOutput("branch_cnt", branchCnt, branchModel[31:0]);
        checkOutput("miss_cnt", missCnt, missModel[31:0]);
        @(posedge clk);
        if (!reset_n) modelReset();
        else if (uValid) modelUpdate(uPc, uIdx, uTaken, uTarget, uMiss);
        #1;
    endtask

    // Combinational peek in the current cycle against a hand-derived constant.
    task automatic peekTarget(input string tag, input logic [31:0] pc, input bit expTaken,
                              input logic [31:0] expTarget);
        fetchPc  = pc;
        updValid = 1'b0;
        #1;
        checkOutput({tag, "_taken"}, {31'd0, predTaken}, {31'd0, expTaken});
        checkOutput({tag, "_target"}, predTarget, expTarget);
    endtask

    task automatic pulseReset(input bit withUpdate);
        reset_n = 1'b0;
        applyStimulus(32'h100, withUpdate, 32'h100, 0, 1'b1, 32'h40, 1'b1);
        reset_n = 1'b1;
    endtask

    initial begin
        int unsigned rPc;
        int unsigned rUpc;
        reset_n  = 1'b0;
        fetchPc  = '0;
        updValid = 1'b0;
        updPc    = '0;
        updIdx   = '0;
        updTaken = 1'b0;
        updTarget = '0;
        updMiss  = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        reset_n = 1'b1;

        // Cold lookup
        peekTarget("cold", 32'h100, 1'b0, 32'h104);
        checkOutput("cold_branch_cnt", branchCnt, 32'd0);

        // Same-cycle training: old prediction now, new prediction next cycle
        applyStimulus(32'h100, 1'b1, 32'h100, 0, 1'b1, 32'h40, 1'b0);
        peekTarget("trained", 32'h100, 1'b1, 32'h40);
        checkOutput("trained_branch_cnt", branchCnt, 32'd1);

        // Aliasing and replacement on index 0
        peekTarget("alias_miss", 32'h200, 1'b0, 32'h204);
        applyStimulus(32'h200, 1'b1, 32'h200, 0, 1'b1, 32'h80, 1'b0);
        peekTarget("alias_new", 32'h200, 1'b1, 32'h80);
        peekTarget("alias_old", 32'h100, 1'b0, 32'h104);

        // PHT saturation at zero
        pulseReset(1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(32'h100, 1'b1, 32'h100, 0, 1'b0, 32'h0, 1'b0);
        applyStimulus(32'h100, 1'b1, 32'h100, 0, 1'b1, 32'h40, 1'b0);
        peekTarget("sat", 32'h100, 1'b0, 32'h104);

        // Statistics and reset winning over a concurrent update
        pulseReset(1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(32'h300, 1'b1, 32'h100, 0, 1'b1, 32'h40, 1'b1);
        fetchPc = 32'h100;
        #1;
        checkOutput("stats_miss_cnt", missCnt, 32'd3);
        checkOutput("stats_branch_cnt", branchCnt, 32'd3);
        pulseReset(1'b1);
        checkOutput("rst_miss_cnt", missCnt, 32'd0);
        checkOutput("rst_branch_cnt", branchCnt, 32'd0);
        peekTarget("rst_lookup", 32'h100, 1'b0, 32'h104);

        // Randomized traffic over a small PC pool to provoke hits and aliasing
        for (int n = 0; n < 3000; n++) begin
            rPc  = ($urandom_range(3) << (IDX_W + 2)) | ($urandom_range(7) << 2) | $urandom_range(3);
            rUpc = ($urandom_range(3) << (IDX_W + 2)) | ($urandom_range(7) << 2) | $urandom_range(3);
            reset_n = ($urandom_range(99) == 0) ? 1'b0 : 1'b1;
            applyStimulus(rPc, $urandom_range(1), rUpc,
                          ($urandom_range(3) == 0) ? $urandom_range(ENTRIES - 1) : pcIndex(rUpc),
                          $urandom_range(1), $urandom, $urandom_range(1));
            reset_n = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch prediction unit for the 5-stage RV32I pipeline. It combines a direct-mapped branch target buffer (BTB) with a pattern history table (PHT) of 2-bit saturating counters. The IF stage queries it combinationally with the current fetch PC to choose the next PC. EX trains it with resolved branch outcomes. It also keeps saturating branch and misprediction counters for the didactic platform's statistics readout.

## Interface
Parameters:
- ENTRIES, 64, number of BTB and PHT entries; power of two, 4..1024; IDX_W = log2(ENTRIES)
- GHR_BITS, 6, global history length; 1..IDX_W; used only with BPU_GSHARE_EN
- CNT_INIT, 2'b01, PHT counter value after reset (weakly not-taken)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- fetch_pc_i  in  32  PC being fetched this cycle
- pred_taken_o  out  1  predicted taken
- pred_target_o  out  32  predicted next PC
- pred_idx_o  out  IDX_W  PHT index used; piped down to EX with the instruction
- upd_valid_i  in  1  resolved branch/jump present in EX this cycle
- upd_pc_i  in  32  PC of the resolved instruction
- upd_idx_i  in  IDX_W  pred_idx_o value captured when that instruction was fetched
- upd_taken_i  in  1  actual outcome
- upd_target_i  in  32  actual target (new_pc)
- upd_miss_i  in  1  misprediction detected (qualified by upd_valid_i)
- branch_cnt_o  out  32  resolved branches since reset
- miss_cnt_o  out  32  mispredictions since reset

## Operation
- Address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
  - pc[1:0] is ignored.
- BTB entry: {valid, tag, target[31:0]}. PHT entry: 2-bit counter.
- Lookup (combinational from fetch_pc_i and current table state):
  - hit = btb.valid[index] && btb.tag[index] == tag(fetch_pc_i)
  - pred_taken_o = hit && pht[pred_idx_o][1]
  - pred_target_o = pred_taken_o ? btb.target[index] : fetch_pc_i + 4 (32-bit, wraps modulo 2^32)
- Update, when upd_valid_i = 1, at the rising edge:
  - PHT: pht[upd_idx_i] increments if upd_taken_i, otherwise decrements.
  - PHT counters saturate at 2'b11 and 2'b00.
  - BTB on taken: entry at index(upd_pc_i) is written {1, tag(upd_pc_i), upd_target_i}. This overwrites any aliasing entry.
  - BTB on not-taken: the BTB is left unchanged.
  - branch_cnt_o increments.
  - miss_cnt_o increments if upd_miss_i is also 1.
  - Both statistics counters saturate at 0xFFFF_FFFF.
- upd_valid_i = 0: no state changes; upd_miss_i is ignored.
- The block holds no stall input. Lookup is pure combinational on fetch_pc_i, so a stalled IF simply re-presents the same PC.

## Timing
- Lookup has 0-cycle latency: outputs are valid in the same cycle as fetch_pc_i.
- Update is visible to lookups from the cycle after the update edge.
- Same-entry lookup and update in the same cycle: the lookup returns the pre-update values; there is no write-through bypass.
- Reset behaviour: while reset_n = 0 at a rising edge, on that edge:
  - all BTB valid bits clear
  - all PHT counters load CNT_INIT
  - GHR clears
  - both statistics counters clear
- Outputs after reset: pred_taken_o = 0, pred_target_o = fetch_pc_i + 4, branch_cnt_o = 0, miss_cnt_o = 0.
- Reset asserted concurrently with upd_valid_i: reset wins and the update is discarded.
- Reset mid-operation takes effect in one cycle; no multi-cycle init sequence.

## Configuration
- BPU_GSHARE_EN defined:
  - A GHR_BITS-wide global history register shifts left on every upd_valid_i, inserting upd_taken_i: ghr <= {ghr[GHR_BITS-2:0], upd_taken_i}.
  - pred_idx_o = index(fetch_pc_i) XOR zero-extended ghr.
  - The GHR is non-speculative: updated at resolution only.
- BPU_GSHARE_EN undefined:
  - No GHR flops are built.
  - pred_idx_o = index(fetch_pc_i), i.e. a bimodal predictor.
- In both cases the PHT update uses upd_idx_i, never a recomputed index.

## Test plan
Directed scenarios; ENTRIES = 64 and BPU_GSHARE_EN undefined unless stated.
- Cold lookup: after reset, fetch_pc_i = 0x100 -> pred_taken_o = 0, pred_target_o = 0x104, branch_cnt_o = 0.
- Training: one update {pc 0x100, idx 0, taken, target 0x40} -> next cycle, lookup of 0x100 gives taken = 1, target = 0x40; branch_cnt_o = 1.
- Aliasing and replacement:
  - After training 0x100, lookup of 0x200 (same index 0, different tag) -> taken = 0, target = 0x204.
  - Then a taken update for 0x200 with target 0x80 -> 0x200 predicts 0x80 and 0x100 now misses.
- Saturation: five not-taken updates on idx 0 (counter 01 -> 00, then holds) followed by one taken update -> counter = 01, lookup predicts not-taken.
- Same-cycle update and lookup: taken update and lookup of the same PC in one cycle -> lookup returns the old prediction that cycle and the new one the next cycle.
- Reset and statistics:
  - Three updates with upd_miss_i = 1 -> miss_cnt_o = 3.
  - reset_n low for one edge -> both counters 0 and all lookups miss.
  - With BPU_GSHARE_EN: after updates taken, taken, pred_idx_o for pc 0x100 = 0x03.
